// File: rtl/cordic_sqrt_scheduler_pkg.sv
// Shared types and widths for the CORDIC square-root scheduler.
package pa_AsyncCordic;

  localparam int unsigned FP32 = 32;
  localparam int unsigned RW   = FP32 + 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWaitHi,
    StWaitLo,
    StResp,
    StHalt
  } t_SchedState;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_sqrt_scheduler_sync.sv
// Single-bit synchroniser bringing the unit's FINISHED into the scheduler clock domain.
module cordic_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic ck_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/cordic_sqrt_scheduler.sv
// Round-robin scheduler sharing one asynchronous CORDIC sqrt unit over a four-phase
// bundled-data handshake, with per-wait timeout and a sticky hung-unit fault.
module cordic_sqrt_scheduler
  import pa_AsyncCordic::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255,
  localparam int unsigned ID_W       = id_width(N_REQ)
) (
  input  logic                      ck,
  input  logic                      arst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0][RW-1:0]  req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RW-1:0]             rsp_data,
  output logic                      rsp_err,
  output logic                      fault,
  output logic                      START,
  output logic [RW-1:0]             DATA_I,
  input  logic                      FINISHED,
  input  logic [RW-1:0]             DATA_O
);

  localparam int unsigned CntW   = $clog2(TIMEOUT + 1);
  localparam int unsigned BlankW = $clog2(SYNC_STAGES + 1);

  t_SchedState       state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d;
  logic [RW-1:0]     data_i_q, data_i_d, result_q, result_d;
  logic              start_q, start_d, err_q, err_d, fault_q, fault_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BlankW-1:0] blank_q, blank_d;

  logic              fin_s, cnt_hit, settled, grant, gnt_found;
  logic [N_REQ-1:0]  rot;
  logic [ID_W:0]     gnt_sum;
  logic [ID_W-1:0]   gnt_idx;

  cordic_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .ck_i (ck),
    .rst_i(arst),
    .d_i  (FINISHED),
    .q_o  (fin_s)
  );

  // Rotate valids so bit 0 is the requester at ptr; lowest set bit wins.
  always_comb begin
    rot       = N_REQ'({req_valid, req_valid} >> ptr_q);
    gnt_found = 1'b0;
    gnt_sum   = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_found = 1'b1;
        gnt_sum   = {1'b0, ptr_q} + (ID_W+1)'(k);
      end
    end
    if (gnt_sum >= (ID_W+1)'(N_REQ)) begin
      gnt_sum = gnt_sum - (ID_W+1)'(N_REQ);
    end
    gnt_idx = gnt_sum[ID_W-1:0];
  end

  assign cnt_hit = (cnt_q == CntW'(TIMEOUT));
  // fin_s is meaningless until the synchroniser has refilled after reset.
  assign settled = (blank_q == BlankW'(SYNC_STAGES));
  assign grant   = (state_q == StIdle) && settled && !fin_s && gnt_found;

  always_ff @(posedge ck) begin
    if (arst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      id_q     <= '0;
      data_i_q <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
      blank_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      data_i_q <= data_i_d;
      result_q <= result_d;
      start_q  <= start_d;
      err_q    <= err_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
      blank_q  <= blank_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    data_i_d = data_i_q;
    result_d = result_q;
    start_d  = start_q;
    err_d    = err_q;
    fault_d  = fault_q;
    cnt_d    = cnt_hit ? cnt_q : cnt_q + 1'b1;
    blank_d  = settled ? blank_q : blank_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          data_i_d = req_data[gnt_idx];
          id_d     = gnt_idx;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (fin_s) begin
          result_d = DATA_O;
          start_d  = 1'b0;
          cnt_d    = '0;
          state_d  = StWaitLo;
        end else if (cnt_hit) begin
          err_d    = 1'b1;
          result_d = '0;
          start_d  = 1'b0;
          cnt_d    = '0;
          state_d  = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!fin_s) begin
          state_d = StResp;
        end else if (cnt_hit) begin
          fault_d = 1'b1;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          err_d   = 1'b0;
          state_d = fault_q ? StHalt : StIdle;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
    rsp_valid = (state_q == StResp);
  end

  assign rsp_id   = id_q;
  assign rsp_data = result_q;
  assign rsp_err  = err_q;
  assign fault    = fault_q;
  assign START    = start_q;
  assign DATA_I   = data_i_q;

endmodule

// File: tb/tb_cordic_sqrt_scheduler.sv
// Directed bench for cordic_sqrt_scheduler with a behavioural four-phase sqrt unit.
module tb_cordic_sqrt_scheduler;
  import pa_AsyncCordic::*;

  localparam int unsigned NReq = 4;
  localparam int unsigned Tmo  = 20;
  localparam logic [RW-1:0] HungData = 33'h0_1234_5678;

  logic                    ck = 1'b0;
  logic                    arst = 1'b1;
  logic [NReq-1:0]         req_valid = '0;
  logic [NReq-1:0][RW-1:0] req_data = '0;
  logic [NReq-1:0]         req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b0;
  logic [id_width(NReq)-1:0] rsp_id;
  logic [RW-1:0]           rsp_data;
  logic                    rsp_err, fault, START;
  logic [RW-1:0]           DATA_I, DATA_O;
  logic                    FINISHED;

  logic                    fin_model = 1'b0;
  logic                    fin_force = 1'b0;
  logic [RW-1:0]           dout_model = '0;
  int                      mode = 0;
  int                      errors = 0;
  int                      checks = 0;

  logic [RW-1:0] op  [4];
  logic [RW-1:0] res [4];

  assign FINISHED = fin_model | fin_force;
  assign DATA_O   = fin_force ? HungData : dout_model;

  always #5 ck = ~ck;

  cordic_sqrt_scheduler #(
    .N_REQ      (NReq),
    .SYNC_STAGES(2),
    .TIMEOUT    (Tmo)
  ) dut (
    .ck       (ck),
    .arst     (arst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .fault    (fault),
    .START    (START),
    .DATA_I   (DATA_I),
    .FINISHED (FINISHED),
    .DATA_O   (DATA_O)
  );

  function automatic logic [RW-1:0] sqrt_lut(input logic [RW-1:0] x);
    case (x)
      33'h0_4080_0000: return 33'h0_4000_0000;
      33'h0_4180_0000: return 33'h0_4080_0000;
      33'h0_3F80_0000: return 33'h0_3F80_0000;
      33'h0_4110_0000: return 33'h0_4040_0000;
      default:         return 33'h1_FFFF_FFFF;
    endcase
  endfunction

  // Zero-delay unit in mode 0; mode 1 never acknowledges.
  initial forever begin
    @(posedge START);
    if (mode == 0) begin
      dout_model = sqrt_lut(DATA_I);
      fin_model  = 1'b1;
      @(negedge START);
      fin_model  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge ck); #1 arst = 1'b1;
    @(posedge ck); #1 arst = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int idx);
    idx = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge ck);
      if (req_ready != '0) begin
        for (int i = 0; i < int'(NReq); i++) if (req_ready[i]) idx = i;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output int lat);
    lat = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge ck);
      if (rsp_valid) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic wait_start(input int budget, output int ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge ck);
      if (START) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int idx, lat, ok, bad;
    op[0] = 33'h0_4080_0000; res[0] = 33'h0_4000_0000;
    op[1] = 33'h0_4180_0000; res[1] = 33'h0_4080_0000;
    op[2] = 33'h0_3F80_0000; res[2] = 33'h0_3F80_0000;
    op[3] = 33'h0_4110_0000; res[3] = 33'h0_4040_0000;

    // Reset state, with all requesters already asking
    req_valid = '1;
    @(posedge ck); @(posedge ck);
    @(negedge ck);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", START, 0);
    chk("rst_data_i", DATA_I, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    req_valid = '0;
    @(posedge ck); #1 arst = 1'b0;

    // Single request
    req_data[2] = op[0];
    req_valid   = 4'b0100;
    rsp_ready   = 1'b1;
    wait_ready(10, idx);
    chk("single_grant", idx, 2);
    @(posedge ck); #1 req_valid = '0;
    @(negedge ck);
    chk("single_data_i", DATA_I, op[0]);
    chk("single_start_setup", START, 0);
    @(negedge ck);
    chk("single_start", START, 1);
    wait_rsp(20, lat);
    chk("single_latency", lat + 2, 8);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_data", rsp_data, res[0]);
    chk("single_rsp_err", rsp_err, 0);
    @(negedge ck);
    chk("single_rsp_done", rsp_valid, 0);

    // Contention from reset: 0,1,2,3 then 0 again
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i] = op[i];
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ready(20, idx);
      chk("cont_grant", idx, k % 4);
      @(posedge ck); #1 if (k > 0 && k < 4) req_valid[k] = 1'b0;
      @(negedge ck);
      chk("cont_data_i", DATA_I, op[k % 4]);
      wait_rsp(40, lat);
      chk("cont_rsp_id", rsp_id, k % 4);
      chk("cont_rsp_data", rsp_data, res[k % 4]);
    end
    req_valid = '0;

    // Backpressure: ptr is 1 now
    @(posedge ck); #1;
    rsp_ready   = 1'b0;
    req_data[1] = op[3];
    req_data[2] = op[2];
    req_valid   = 4'b0110;
    wait_ready(20, idx);
    chk("bp_grant", idx, 1);
    @(posedge ck); #1 req_valid[1] = 1'b0;
    wait_rsp(40, lat);
    chk("bp_rsp_seen", lat > 0, 1);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge ck);
      if (!(rsp_valid === 1'b1 && rsp_data === res[3] && rsp_id === 2'd1 && req_ready === 4'b0))
        bad++;
    end
    chk("bp_hold", bad, 0);
    @(posedge ck); #1 rsp_ready = 1'b1;
    @(negedge ck);
    @(negedge ck);
    chk("bp_released", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0100);
    @(posedge ck); #1 req_valid = '0;
    wait_rsp(40, lat);
    chk("bp_next_id", rsp_id, 2);
    chk("bp_next_data", rsp_data, res[2]);

    // Timeout: unit never acknowledges (ptr is 3)
    @(posedge ck); #1;
    mode        = 1;
    req_data[3] = op[0];
    req_valid   = 4'b1000;
    wait_ready(20, idx);
    chk("to_grant", idx, 3);
    @(posedge ck); #1 req_valid = '0;
    @(negedge ck);
    @(negedge ck);
    chk("to_start", START, 1);
    wait_rsp(60, lat);
    chk("to_latency", lat + 2, 24);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 0);
    chk("to_start_low", START, 0);
    chk("to_fault", fault, 0);
    chk("to_id", rsp_id, 3);

    // Normal service after a timeout
    @(posedge ck); #1;
    mode        = 0;
    req_data[0] = op[2];
    req_valid   = 4'b0001;
    wait_ready(20, idx);
    chk("after_to_grant", idx, 0);
    @(posedge ck); #1 req_valid = '0;
    wait_rsp(40, lat);
    chk("after_to_data", rsp_data, res[2]);
    chk("after_to_err", rsp_err, 0);

    // Hung acknowledge: FINISHED stuck high
    @(posedge ck); #1;
    mode        = 1;
    req_data[1] = op[1];
    req_valid   = 4'b0010;
    wait_ready(20, idx);
    chk("hung_grant", idx, 1);
    @(posedge ck); #1 req_valid = '0;
    wait_start(10, ok);
    chk("hung_start", ok, 1);
    fin_force = 1'b1;
    wait_rsp(80, lat);
    chk("hung_err", rsp_err, 1);
    chk("hung_fault", fault, 1);
    chk("hung_data", rsp_data, HungData);
    @(posedge ck); #1 req_valid = '1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge ck);
      if (req_ready !== 4'b0 || START !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    chk("halt_quiet", bad, 0);
    chk("halt_fault_sticky", fault, 1);

    // Reset clears the fault; FINISHED still high blocks grants
    do_reset();
    @(negedge ck);
    chk("clr_fault", fault, 0);
    chk("clr_rsp_err", rsp_err, 0);
    chk("clr_start", START, 0);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (req_ready !== 4'b0) bad++;
      @(negedge ck);
    end
    chk("fin_high_block", bad, 0);
    @(posedge ck); #1;
    fin_force = 1'b0;
    mode      = 0;
    wait_ready(10, idx);
    chk("post_clr_grant", idx, 0);
    @(posedge ck); #1 req_valid = 4'b0100;
    wait_rsp(40, lat);
    chk("post_clr_rsp_id", rsp_id, 0);
    chk("post_clr_rsp_data", rsp_data, res[2]);

    // Reset mid-operation in WAIT_HI (ptr is 1 before reset)
    mode = 1;
    wait_ready(10, idx);
    chk("midop_grant", idx, 2);
    @(posedge ck); #1 req_valid = '1;
    wait_start(10, ok);
    chk("midop_start", ok, 1);
    do_reset();
    fin_force = 1'b1;
    @(negedge ck);
    chk("midop_start_low", START, 0);
    chk("midop_data_i", DATA_I, 0);
    chk("midop_rsp_valid", rsp_valid, 0);
    chk("midop_rsp_id", rsp_id, 0);
    chk("midop_rsp_data", rsp_data, 0);
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      if (req_ready !== 4'b0) bad++;
      @(negedge ck);
    end
    chk("midop_block", bad, 0);
    @(posedge ck); #1 fin_force = 1'b0;
    wait_ready(10, idx);
    chk("midop_ptr_zero", idx, 0);
    @(posedge ck); #1 req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_sqrt_scheduler.md
# cordic_sqrt_scheduler

Round-robin scheduler that shares one asynchronous CORDIC square-root unit between `N_REQ` synchronous requesters. It owns the unit's bundled-data four-phase handshake: it drives `DATA_I` and `START`, synchronises `FINISHED` into the `ck` domain, captures `DATA_O`, and returns the result with the requester's index. It sits between the per-client request logic and the async unit, and also guards against a hung unit with a timeout and a sticky fault flag.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters, 2..16.
- `SYNC_STAGES`, 2 — flops in the `FINISHED` synchroniser, ≥2.
- `TIMEOUT`, 255 — maximum cycles allowed in each wait state.

Ports:
- `ck`  in  1 — clock.
- `arst`  in  1 — reset; one clock, reset is synchronous and active-high.
- `req_valid`  in  N_REQ — per-requester operand valid.
- `req_data`  in  N_REQ×(FP32+1) — per-requester operand.
- `req_ready`  out  N_REQ — one-hot, one-cycle grant/accept pulse.
- `rsp_valid`  out  1 — result available.
- `rsp_ready`  in  1 — result consumed.
- `rsp_id`  out  max(1,$clog2(N_REQ)) — index of the requester that owns the result.
- `rsp_data`  out  FP32+1 — square-root result.
- `rsp_err`  out  1 — result invalid (timeout).
- `fault`  out  1 — sticky hung-unit flag.
- `START`  out  1 — request to the CORDIC unit.
- `DATA_I`  out  FP32+1 — operand to the unit.
- `FINISHED`  in  1 — asynchronous acknowledge from the unit.
- `DATA_O`  in  FP32+1 — unit result; stable while `FINISHED` is high.

## Operation
- States: `IDLE`, `SETUP`, `WAIT_HI`, `WAIT_LO`, `RESP`, `HALT`.
- `fin_s` is `FINISHED` after `SYNC_STAGES` flops.
- `IDLE`:
  - Grants only when `fin_s==0`.
  - Round-robin search starts at `ptr`. Among simultaneous valids, the first index ≥ `ptr` (cyclic) wins.
  - On grant: `req_ready[i]=1`, the operand is latched into `DATA_I`, `id←i`, then go to `SETUP`.
- `SETUP`: `DATA_I` is held for one cycle (bundled-data setup), then `START←1` and go to `WAIT_HI`.
- `WAIT_HI`:
  - On `fin_s==1`: `result←DATA_O`, `START←0`, go to `WAIT_LO`.
  - If the counter reaches `TIMEOUT`: `rsp_err←1`, `result←0`, `START←0`, go to `WAIT_LO`.
- `WAIT_LO`:
  - On `fin_s==0`: go to `RESP`.
  - If the counter reaches `TIMEOUT`: `fault←1`, `rsp_err←1`, go to `RESP`.
- `RESP`:
  - `rsp_valid=1` with `rsp_id`, `rsp_data`, `rsp_err` held stable.
  - On `rsp_ready`: `ptr←(id+1) mod N_REQ`, clear `rsp_err`, then go to `IDLE`, or to `HALT` if `fault`.
- `HALT`: no grants, `START=0`. Exited only by `arst`.
- The timeout counter clears on entry to each wait state and saturates.
- `DATA_I` holds its value from `SETUP` until the next grant.

## Timing
- Reset (`arst` high at a rising edge):
  - State `IDLE`; all outputs 0.
  - `ptr=0`, counter 0, synchroniser flops 0, `fault=0`.
  - Applies mid-operation too; any in-flight result is discarded.
- After reset, a `FINISHED` that is still high blocks grants until `fin_s` falls. The unit's previous cycle is never re-acknowledged.
- Grant at edge t → `DATA_I` valid at t+1 → `START` high at t+2.
- `FINISHED` rising → `fin_s` high `SYNC_STAGES` cycles later → `START` low next edge.
- `FINISHED` falling → `fin_s` low `SYNC_STAGES` cycles later → `rsp_valid` next edge.
- With an ideal zero-delay unit and `SYNC_STAGES=2`, grant-to-`rsp_valid` is 8 cycles.
- `req_ready` is never asserted while `rsp_valid` is high. One operation is in flight at a time.
- `rsp_ready` asserted in the same cycle `rsp_valid` rises completes the transfer in that cycle. The next grant can occur in the following `IDLE` cycle.
- A `req_valid` dropped before grant is simply not served; requesters hold `req_data` while `req_valid` is high.

## Structure
- `pa_AsyncCordic` holds the shared items:
  - `RW` and `FP32`.
  - A state enum type `t_SchedState`.
  - Localparam `ID_W` computation helper.
- One sub-module, `cordic_sync`: a `SYNC_STAGES`-deep single-bit synchroniser with synchronous active-high reset to 0.
- Arbitration, FSM, counter and datapath registers stay in `cordic_sqrt_scheduler`.
- Bench interface: extend the existing CORDIC test interface with the request/response ports.

## Test plan
- Single request: `req_valid[2]=1`, `req_data=32'h4080_0000` (4.0), model returns `32'h4000_0000` → `req_ready[2]` pulse, `START` 2 cycles later, `rsp_id=2`, `rsp_data=32'h4000_0000`, `rsp_err=0`.
- Contention: all 4 valid at once from reset → service order 0,1,2,3, then 0 again if it is still valid. Each `DATA_I` equals its requester's operand.
- Backpressure: hold `rsp_ready=0` for 20 cycles → `rsp_valid`/`rsp_data` stable, no `req_ready` during that time.
- Timeout: model never raises `FINISHED` → after `TIMEOUT` cycles `START=0`, `rsp_err=1`, `rsp_data=0`. The next request is served normally.
- Hung acknowledge: `FINISHED` stuck high → `rsp_err=1`, `fault=1`, `HALT` with no further grants; `arst` clears `fault`.
- Reset mid-op: `arst` in `WAIT_HI` with `FINISHED` later high → all outputs 0, no grant until `FINISHED` returns low, `ptr=0`.
